decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_AW, default 3, register address width; NUM_REGS = 2**REG_AW.
REQ-003 SHALL have parameter SIG_W, default 40, control-vector width.
REQ-004 SHALL have parameter IN_SEL_BIT, default 18, control bit selecting in_port as operand 1.
REQ-005 SHALL have parameter MEM_RD_BIT, default 19, control bit marking a load.
REQ-006 SHALL have one clock and an asynchronous active-low reset, as the ports below:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_ready  out  1  instruction accepted this cycle.
- ctrl_in  in  SIG_W  control vector from the control unit.
- rsrc1, rsrc2, rdst  in  REG_AW each  register addresses.
- in_port  in  DATA_W  external input port.
- wb_en  in  1  writeback write enable.
- wb_addr  in  REG_AW  writeback address.
- wb_data  in  DATA_W  writeback data.
- ex_stall  in  1  downstream hold request.
- flush  in  1  squash the ID/EX register.
- out_valid  out  1  ID/EX entry valid.
- out_ctrl  out  SIG_W  registered control vector.
- out_data1, out_data2  out  DATA_W  registered operands.
- out_rsrc1, out_rsrc2, out_rdst  out  REG_AW  registered addresses.
- bubble_cnt  out  16  saturating count of inserted hazard bubbles.

Function
REQ-007 SHALL contain NUM_REGS x DATA_W registers, all writable, written on the rising edge when wb_en=1.
REQ-008 Reads SHALL be combinational; if wb_en=1 and wb_addr equals a read address, that read SHALL return wb_data (write-before-read bypass).
REQ-009 Operand 1 SHALL be in_port when ctrl_in[IN_SEL_BIT]=1, otherwise the bypassed read of rsrc1; operand 2 SHALL be the bypassed read of rsrc2.
REQ-010 hazard SHALL be 1 when all of these hold: in_valid=1, out_valid=1, out_ctrl[MEM_RD_BIT]=1, and either (out_rdst==rsrc1 and ctrl_in[IN_SEL_BIT]=0) or out_rdst==rsrc2.
REQ-011 in_ready SHALL equal !hazard && !ex_stall, combinationally.
REQ-012 The ID/EX register SHALL update each rising edge with this priority: flush > ex_stall > hazard > normal.
- flush: out_valid=0, out_ctrl=0; the instruction is not accepted.
- ex_stall: all outputs hold.
- hazard: bubble, i.e. out_valid=0 and out_ctrl=0; data/address outputs don't-care; the instruction is held upstream.
- normal: capture in_valid, ctrl_in (zeroed if in_valid=0), operands, and addresses.
REQ-013 Latency from an accepted instruction to out_valid=1 SHALL be exactly 1 cycle.
REQ-014 A load-use hazard SHALL insert exactly one bubble; the following cycle the instruction SHALL be accepted with the loaded value available through the bypass or the register file.
REQ-015 bubble_cnt SHALL increment by 1 on each edge taking the hazard branch and saturate at 16'hFFFF.
REQ-016 A register-file write SHALL occur even during flush, ex_stall or hazard.
REQ-017 When flush and ex_stall are both 1, flush SHALL win.

Reset
REQ-018 While rst=0, asynchronously:
- all registers and all ID/EX outputs SHALL be 0;
- bubble_cnt SHALL be 0;
- out_valid SHALL be 0.
REQ-019 A reset asserted mid-stall SHALL discard the held entry; after rst rises, the first edge with in_valid=1 and no hazard SHALL capture normally.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Write-read bypass: wb_en=1, wb_addr=3, wb_data=16'h00A5 in the same cycle as rsrc1=3 -> next cycle out_data1=16'h00A5.
- In-port select: ctrl_in[18]=1, in_port=16'h1234, R1=16'h0007, rsrc1=1 -> out_data1=16'h1234, and no hazard even if out_rdst=1 with a load in EX.
- Load-use: load with rdst=2 in EX; next instruction has rsrc2=2 -> one cycle in_ready=0, out_valid=0, bubble_cnt=1; then accepted with out_valid=1.
- ex_stall: ex_stall=1 for 3 cycles with a valid entry -> out_* unchanged and in_ready=0 throughout; capture resumes on the first cycle after ex_stall=0.
- Flush with stall: flush=1 and ex_stall=1 together -> next cycle out_valid=0 and out_ctrl=0.
- Reset: rst=0 asserted mid-operation -> all outputs immediately 0; bubble_cnt preloaded near 16'hFFFF saturates at 16'hFFFF and never wraps.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: instruction-decode stage with register file, write-before-read bypass,
// load-use hazard detection and the ID/EX pipeline register.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      decode-slot handshake (in_ready = !hazard && !ex_stall)
//   ctrl_in                  control vector from the control unit
//   rsrc1, rsrc2, rdst       register addresses of the decoding instruction
//   in_port                  external input port, selectable as operand 1
//   wb_en, wb_addr, wb_data  register-file writeback
//   ex_stall, flush          downstream hold / squash of the ID/EX register
//   out_*                    registered ID/EX entry
//   bubble_cnt               saturating count of inserted load-use bubbles
module decode_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned SIG_W      = 40,
  parameter int unsigned IN_SEL_BIT = 18,
  parameter int unsigned MEM_RD_BIT = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIG_W-1:0]  ctrl_in,
  input  logic [REG_AW-1:0] rsrc1,
  input  logic [REG_AW-1:0] rsrc2,
  input  logic [REG_AW-1:0] rdst,
  input  logic [DATA_W-1:0] in_port,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [SIG_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [REG_AW-1:0] out_rsrc1,
  output logic [REG_AW-1:0] out_rsrc2,
  output logic [REG_AW-1:0] out_rdst,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Operand selection with same-cycle writeback bypass
  logic [DATA_W-1:0] rd1, rd2, op1;
  logic              hazard;

  always_comb begin
    rd1    = (wb_en && (wb_addr == rsrc1)) ? wb_data : rf_q[rsrc1];
    rd2    = (wb_en && (wb_addr == rsrc2)) ? wb_data : rf_q[rsrc2];
    op1    = ctrl_in[IN_SEL_BIT] ? in_port : rd1;
    // A load in EX whose result is needed now; rsrc1 is not a dependency when in_port is used.
    hazard = in_valid && out_valid && out_ctrl[MEM_RD_BIT] &&
             (((out_rdst == rsrc1) && !ctrl_in[IN_SEL_BIT]) || (out_rdst == rsrc2));
    in_ready = !hazard && !ex_stall;
  end

  // ID/EX register
  logic              valid_q, valid_d;
  logic [SIG_W-1:0]  ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [15:0]       bubble_q, bubble_d;

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    bubble_d = bubble_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (ex_stall) begin
      // hold everything
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    end else begin
      valid_d = in_valid;
      ctrl_d  = in_valid ? ctrl_in : '0;
      data1_d = op1;
      data2_d = rd2;
      rs1_d   = rsrc1;
      rs2_d   = rsrc2;
      rd_d    = rdst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign out_data1  = data1_q;
  assign out_data2  = data2_q;
  assign out_rsrc1  = rs1_q;
  assign out_rsrc2  = rs2_q;
  assign out_rdst   = rd_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Testbench for decode_pipe: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the decode stage.
module tb_decode_pipe;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int SW  = 40;
  localparam int INS = 18;
  localparam int MRD = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] ctrl_in;
  logic [AW-1:0] rsrc1, rsrc2, rdst;
  logic [DW-1:0] in_port;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_stall;
  logic          flush;
  logic          out_valid;
  logic [SW-1:0] out_ctrl;
  logic [DW-1:0] out_data1, out_data2;
  logic [AW-1:0] out_rsrc1, out_rsrc2, out_rdst;
  logic [15:0]   bubble_cnt;

  decode_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ctrl_in    (ctrl_in),
    .rsrc1      (rsrc1),
    .rsrc2      (rsrc2),
    .rdst       (rdst),
    .in_port    (in_port),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ctrl   (out_ctrl),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_rsrc1  (out_rsrc1),
    .out_rsrc2  (out_rsrc2),
    .out_rdst   (out_rdst),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: register file contents and the expected pipeline entry
  logic [DW-1:0] m_rf [8];
  logic          m_valid;
  logic [SW-1:0] m_ctrl;
  logic [DW-1:0] m_d1, m_d2;
  logic [AW-1:0] m_rs1, m_rs2, m_rd;
  int unsigned   m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_d1    = '0;
    m_d2    = '0;
    m_rs1   = '0;
    m_rs2   = '0;
    m_rd    = '0;
    m_cnt   = 0;
  endtask

  function automatic logic model_hazard();
    return in_valid && m_valid && m_ctrl[MRD] &&
           (((m_rd == rsrc1) && !ctrl_in[INS]) || (m_rd == rsrc2));
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (flush) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else if (ex_stall) begin
      // entry held
    end else if (hz) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
      if (m_cnt < 32'hFFFF) m_cnt++;
    end else begin
      m_valid = in_valid;
      m_ctrl  = in_valid ? ctrl_in : '0;
      m_d1    = ctrl_in[INS] ? in_port : model_read(rsrc1);
      m_d2    = model_read(rsrc2);
      m_rs1   = rsrc1;
      m_rs2   = rsrc2;
      m_rd    = rdst;
    end
    if (wb_en) m_rf[wb_addr] = wb_data;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    chk("in_ready", 64'(in_ready), 64'(!model_hazard() && !ex_stall));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("out_data1", 64'(out_data1), 64'(m_d1));
      chk("out_data2", 64'(out_data2), 64'(m_d2));
      chk("out_rsrc1", 64'(out_rsrc1), 64'(m_rs1));
      chk("out_rsrc2", 64'(out_rsrc2), 64'(m_rs2));
      chk("out_rdst", 64'(out_rdst), 64'(m_rd));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ctrl_in  = '0;
    rsrc1    = '0;
    rsrc2    = '0;
    rdst     = '0;
    in_port  = '0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    ex_stall = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
    chk({tag, "_data"}, 64'({out_data1, out_data2}), 64'd0);
    chk({tag, "_addr"}, 64'({out_rsrc1, out_rsrc2, out_rdst}), 64'd0);
    chk({tag, "_bubble"}, 64'(bubble_cnt), 64'd0);
  endtask

  // Asserts reset away from any clock edge and checks the asynchronous clear.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [SW-1:0] ld_ctrl;

  initial begin
    idle();
    model_reset();
    ld_ctrl      = '0;
    ld_ctrl[MRD] = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Load-use: one bubble then acceptance
    in_valid = 1'b1; ctrl_in = ld_ctrl; rdst = 3'd2; rsrc1 = 3'd5; rsrc2 = 3'd6;
    step();
    ctrl_in = 40'h0000_0001; rsrc1 = 3'd0; rsrc2 = 3'd2; rdst = 3'd4;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
    step();
    chk("lu_bubble_valid", 64'(out_valid), 64'd0);
    chk("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    wb_en = 1'b0;
    step();
    chk("lu_accept_valid", 64'(out_valid), 64'd1);
    chk("lu_loaded_data2", 64'(out_data2), 64'hBEEF);

    // Write-before-read bypass
    idle();
    in_valid = 1'b1; rsrc1 = 3'd3; wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h00A5;
    step();
    chk("bypass_data1", 64'(out_data1), 64'h00A5);

    // In-port select, no hazard against a load to R1 in EX
    idle();
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0007;
    step();
    idle();
    in_valid = 1'b1; ctrl_in = ld_ctrl; rdst = 3'd1;
    step();
    ctrl_in = '0; ctrl_in[INS] = 1'b1; in_port = 16'h1234; rsrc1 = 3'd1; rsrc2 = 3'd0;
    rdst = 3'd5;
    #1 chk("inport_no_hazard", 64'(in_ready), 64'd1);
    #0 step();
    chk("inport_data1", 64'(out_data1), 64'h1234);

    // ex_stall holds the entry for 3 cycles
    idle();
    in_valid = 1'b1; ctrl_in = 40'h55; rsrc1 = 3'd5; rsrc2 = 3'd6; rdst = 3'd7;
    step();
    ex_stall = 1'b1; ctrl_in = 40'h33; rdst = 3'd3;
    repeat (3) begin
      step();
      chk("stall_ctrl_held", 64'(out_ctrl), 64'h55);
      chk("stall_rdst_held", 64'(out_rdst), 64'd7);
    end
    ex_stall = 1'b0; ctrl_in = 40'hAA;
    step();
    chk("stall_resume_ctrl", 64'(out_ctrl), 64'hAA);

    // Flush beats ex_stall
    flush = 1'b1; ex_stall = 1'b1;
    step();
    chk("flush_stall_valid", 64'(out_valid), 64'd0);
    chk("flush_stall_ctrl", 64'(out_ctrl), 64'd0);

    // Reset during a stall discards the held entry
    idle();
    in_valid = 1'b1; ctrl_in = 40'h11; rdst = 3'd2;
    step();
    ex_stall = 1'b1;
    step();
    mid_reset("stall_reset");
    ex_stall = 1'b0; ctrl_in = 40'h22;
    step();
    chk("post_reset_capture", 64'(out_ctrl), 64'h22);

    // Saturation of the bubble counter
    idle();
    dut.bubble_q = 16'hFFFD;
    m_cnt        = 32'hFFFD;
    repeat (5) begin
      in_valid = 1'b1; ctrl_in = ld_ctrl; rdst = 3'd4; rsrc1 = 3'd0; rsrc2 = 3'd0;
      step();
      ctrl_in = '0; rsrc1 = 3'd4;
      step();
    end
    chk("bubble_saturated", 64'(bubble_cnt), 64'hFFFF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(3) != 0);
      ctrl_in  = {8'($urandom), 32'($urandom)};
      ctrl_in[MRD] = ($urandom_range(2) == 0);
      ctrl_in[INS] = ($urandom_range(3) == 0);
      rsrc1    = AW'($urandom);
      rsrc2    = AW'($urandom);
      rdst     = AW'($urandom);
      in_port  = DW'($urandom);
      wb_en    = ($urandom_range(1) == 0);
      wb_addr  = AW'($urandom);
      wb_data  = DW'($urandom);
      ex_stall = ($urandom_range(4) == 0);
      flush    = ($urandom_range(9) == 0);
      step();
    end

    // Reset mid-operation clears everything
    mid_reset("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
